layer_scroller: RTL and testbench
=================================

Name: layer_scroller

Overview:
Upstream control stage for draw_layer: owns one platform layer's vertical position and block pattern, and drives draw_layer's ypos, layer_map and block_type.
- Once per frame (on the vsync rising edge), it advances ypos by a programmable speed.
- When the layer scrolls off the bottom of the screen, it wraps ypos and regenerates a new 7-block pattern from a free-running LFSR.
- All outputs change only at frame start, so draw_layer never sees a mid-frame update.

Parameters:
INIT_YPOS, 0, ypos value after reset (0..WRAP_YPOS-1)
WRAP_YPOS, 725, wrap threshold: screen height 600 + draw OFFSET_Y 100 + block height 25
LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero
MIN_BLOCKS, 2, minimum number of set bits in a regenerated layer_map (0..8; 8 is unsatisfiable and is used in test)

Ports:
pclk  in  1  pixel clock; the only clock
rst  in  1  synchronous, active-high reset
vsync_in  in  1  VGA vsync from the timing chain
enable  in  1  scroll enable; held low during menus and game over
speed  in  3  pixels per frame added to ypos (0..7)
layer_map  out  [0:6]  block present, index 0 = leftmost block
block_type  out  [0:6]  1 = sky block, 0 = ground block
ypos  out  12  layer top position in draw_layer coordinates
wrapped  out  1  one-cycle pulse when a new pattern is committed

Behaviour:
Reset values:
- ypos=INIT_YPOS, layer_map=7'b1111111, block_type=7'b0000000, wrapped=0.
- state=IDLE, lfsr=LFSR_SEED, retry count=0, vsync_d=0.

Frame tick:
- vsync_d is a register copy of vsync_in.
- tick = vsync_in & ~vsync_d (combinational).
- Exactly one tick per vsync rising edge.

LFSR:
- 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1; shifts every pclk cycle in every state.
- If the LFSR value reaches 0, reload LFSR_SEED on the next cycle.

State machine:
- IDLE: if enable=1, go to SCROLL; otherwise ypos is held.
- SCROLL:
  - enable=0: go to IDLE. A tick in the same cycle is ignored.
  - tick with enable=1: compute sum = ypos + speed (13-bit).
    - sum < WRAP_YPOS: ypos <= sum.
    - otherwise: ypos <= sum - WRAP_YPOS and go to REGEN with retry=0.
  - speed=0: ypos is unchanged and no wrap occurs.
- REGEN (one candidate per cycle; enable is ignored while in this state):
  - Candidate map = lfsr[6:0], with lfsr[6] going to layer_map[0]. Candidate type = lfsr[13:7].
  - popcount(map) >= MIN_BLOCKS: commit map and type, pulse wrapped for 1 cycle, go to SCROLL.
  - Otherwise: retry += 1 and stay in REGEN.
  - On the 8th rejected candidate: commit layer_map=7'b0011100, block_type=0, pulse wrapped, go to SCROLL.
  - Worst-case REGEN duration is 8 cycles, well inside vertical blanking.

Update latency:
- ypos updates on the clock edge that samples the tick (visible 1 cycle after vsync_in is first seen high).
- layer_map and block_type update 1 to 8 cycles after that.

Other rules:
- A tick arriving during REGEN is dropped.
- Reset in any state, including mid-REGEN, restores all reset values on the next edge.
- Outputs are registered, with no combinational path from input to output.

Optional Feature:
SKY_BLOCKS_EN
- Defined: block_type is taken from the LFSR as above.
- Undefined: block_type is forced to 7'b0000000 at all times (all ground); the LFSR type bits are unused.
- ypos and layer_map behaviour is identical in both builds.

Test Plan:
1. Reset with INIT_YPOS=0 -> ypos=0, layer_map=7'b1111111, block_type=0, wrapped=0, all held until enable is raised.
2. enable=1, speed=3, 4 vsync rising edges -> ypos=3, 6, 9, 12, each step 1 cycle after the edge; vsync held high for many cycles produces only one step per edge.
3. INIT_YPOS=720, speed=7, one tick -> ypos=2; wrapped pulses exactly once within 8 cycles; new layer_map has popcount >= 2.
4. MIN_BLOCKS=8 -> after a wrap, 8 REGEN cycles, then layer_map=7'b0011100, block_type=0, single wrapped pulse.
5. enable dropped in the same cycle as a tick -> ypos unchanged; after 3 further ticks, ypos is still unchanged; speed=0 with enable=1 -> ypos constant.
6. rst asserted on cycle 2 of REGEN (MIN_BLOCKS=8) -> next edge restores the reset values; no wrapped pulse; the LFSR restarts at 16'hACE1. SKY_BLOCKS_EN undefined build -> block_type=0 after 10 wraps.

Source files
------------

// File: rtl/layer_scroller.sv
// Scroll/regenerate controller for one draw_layer platform row: frame-tick ypos advance,
// wrap, and LFSR-driven block pattern. Build option SKY_BLOCKS_EN enables random sky blocks.
module layer_scroller #(
  parameter int unsigned INIT_YPOS  = 0,
  parameter int unsigned WRAP_YPOS  = 725,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int unsigned MIN_BLOCKS = 2
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vsync_in,
  input  logic        enable,
  input  logic [2:0]  speed,
  output logic [0:6]  layer_map,
  output logic [0:6]  block_type,
  output logic [11:0] ypos,
  output logic        wrapped
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCROLL,
    ST_REGEN
  } state_e;

  localparam logic [11:0] INIT12 = 12'(INIT_YPOS);
  localparam logic [12:0] WRAP13 = 13'(WRAP_YPOS);
  localparam logic [3:0]  MIN_B  = 4'(MIN_BLOCKS);
  localparam logic [0:6]  FALLBACK_MAP = 7'b0011100;

  state_e      state_q;
  logic [15:0] lfsr_q, lfsr_d;
  logic [2:0]  retry_q;
  logic        vsync_q;
  logic [11:0] ypos_q;
  logic [0:6]  map_q;
  logic        wrapped_q;
  logic        tick;
  logic [12:0] sum;
  logic [3:0]  pop;
  logic        fb;

`ifdef SKY_BLOCKS_EN
  logic [0:6]  type_q;
`endif

  always_comb begin
    tick = vsync_in & ~vsync_q;
    sum  = {1'b0, ypos_q} + 13'(speed);
    pop  = '0;
    for (int unsigned i = 0; i < 7; i++) begin
      pop = pop + 4'(lfsr_q[i]);
    end
    fb     = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    lfsr_d = (lfsr_q == '0) ? LFSR_SEED : {fb, lfsr_q[15:1]};
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      lfsr_q    <= LFSR_SEED;
      retry_q   <= '0;
      vsync_q   <= 1'b0;
      ypos_q    <= INIT12;
      map_q     <= '1;
      wrapped_q <= 1'b0;
`ifdef SKY_BLOCKS_EN
      type_q    <= '0;
`endif
    end else begin
      vsync_q   <= vsync_in;
      lfsr_q    <= lfsr_d;
      wrapped_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (enable) state_q <= ST_SCROLL;
        end
        ST_SCROLL: begin
          if (!enable) begin
            state_q <= ST_IDLE;
          end else if (tick) begin
            if (sum < WRAP13) begin
              ypos_q <= sum[11:0];
            end else begin
              ypos_q  <= 12'(sum - WRAP13);
              retry_q <= '0;
              state_q <= ST_REGEN;
            end
          end
        end
        ST_REGEN: begin
          // lfsr[6] lands in layer_map[0] because the map is declared [0:6]
          if (pop >= MIN_B) begin
            map_q     <= lfsr_q[6:0];
`ifdef SKY_BLOCKS_EN
            type_q    <= lfsr_q[13:7];
`endif
            wrapped_q <= 1'b1;
            state_q   <= ST_SCROLL;
          end else if (retry_q == 3'd7) begin
            map_q     <= FALLBACK_MAP;
`ifdef SKY_BLOCKS_EN
            type_q    <= '0;
`endif
            wrapped_q <= 1'b1;
            state_q   <= ST_SCROLL;
          end else begin
            retry_q <= retry_q + 3'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign layer_map = map_q;
  assign ypos      = ypos_q;
  assign wrapped   = wrapped_q;
`ifdef SKY_BLOCKS_EN
  assign block_type = type_q;
`else
  assign block_type = '0;
`endif

endmodule

// File: tb/tb_layer_scroller.sv
// Bench for layer_scroller: three configurations driven together, checked every cycle
// against a frame-level reference model plus directed scenario checks.
module tb_layer_scroller;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam int unsigned INIT [3] = '{0, 720, 720};
  localparam int unsigned WRAP [3] = '{40, 725, 725};
  localparam int unsigned MINB [3] = '{2, 2, 8};

  logic        pclk = 1'b0;
  logic        rst, vsync, en;
  logic [2:0]  spd    [3];
  logic [0:6]  map_o  [3];
  logic [0:6]  type_o [3];
  logic [11:0] ypos_o [3];
  logic        wr_o   [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 pclk = ~pclk;

  layer_scroller #(.INIT_YPOS(0), .WRAP_YPOS(40), .LFSR_SEED(16'hACE1), .MIN_BLOCKS(2)) u_dut0 (
    .pclk(pclk), .rst(rst), .vsync_in(vsync), .enable(en), .speed(spd[0]),
    .layer_map(map_o[0]), .block_type(type_o[0]), .ypos(ypos_o[0]), .wrapped(wr_o[0]));

  layer_scroller #(.INIT_YPOS(720), .WRAP_YPOS(725), .LFSR_SEED(16'hACE1), .MIN_BLOCKS(2)) u_dut1 (
    .pclk(pclk), .rst(rst), .vsync_in(vsync), .enable(en), .speed(spd[1]),
    .layer_map(map_o[1]), .block_type(type_o[1]), .ypos(ypos_o[1]), .wrapped(wr_o[1]));

  layer_scroller #(.INIT_YPOS(720), .WRAP_YPOS(725), .LFSR_SEED(16'hACE1), .MIN_BLOCKS(8)) u_dut2 (
    .pclk(pclk), .rst(rst), .vsync_in(vsync), .enable(en), .speed(spd[2]),
    .layer_map(map_o[2]), .block_type(type_o[2]), .ypos(ypos_o[2]), .wrapped(wr_o[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: frame-level behaviour; a wrap pre-plans the whole regeneration outcome.
  logic [15:0] m_lfsr;
  logic        m_vs;
  int unsigned m_ypos  [3];
  logic [0:6]  m_map   [3];
  logic [0:6]  m_type  [3];
  logic        m_wr    [3];
  int          m_mode  [3];   // 0 idle, 1 scrolling, 2 regenerating
  int          m_busy  [3];
  logic [0:6]  m_pmap  [3];
  logic [0:6]  m_ptype [3];
  int          m_wcnt = 0;
  int          d_wcnt = 0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic fbit;
    fbit = ^(v & 16'h002D);
    return (v >> 1) | (16'(fbit) << 15);
  endfunction

  task automatic plan_regen(input int i, input logic [15:0] first);
    logic [15:0] c;
    bit found;
    c = first;
    found = 0;
    for (int k = 0; k < 8; k++) begin
      if (!found) begin
        if ($countones(c[6:0]) >= MINB[i]) begin
          found = 1;
          m_busy[i] = k + 1;
          for (int b = 0; b < 7; b++) begin
            m_pmap[i][b] = c[6-b];
`ifdef SKY_BLOCKS_EN
            m_ptype[i][b] = c[13-b];
`else
            m_ptype[i][b] = 1'b0;
`endif
          end
        end else begin
          c = lfsr_step(c);
        end
      end
    end
    if (!found) begin
      m_busy[i]  = 8;
      m_pmap[i]  = 7'b0011100;
      m_ptype[i] = '0;
    end
  endtask

  always @(posedge pclk) begin : model
    logic tk;
    logic [15:0] nxt;
    int unsigned s;
    tk  = vsync && !m_vs;
    nxt = (m_lfsr == 16'h0) ? SEED : lfsr_step(m_lfsr);
    for (int i = 0; i < 3; i++) begin
      m_wr[i] = 1'b0;
      if (rst) begin
        m_ypos[i] = INIT[i];
        m_map[i]  = '1;
        m_type[i] = '0;
        m_mode[i] = 0;
        m_busy[i] = 0;
      end else begin
        case (m_mode[i])
          0: if (en) m_mode[i] = 1;
          1: begin
            if (!en) begin
              m_mode[i] = 0;
            end else if (tk) begin
              s = m_ypos[i] + spd[i];
              if (s < WRAP[i]) begin
                m_ypos[i] = s;
              end else begin
                m_ypos[i] = s - WRAP[i];
                plan_regen(i, nxt);
                m_mode[i] = 2;
              end
            end
          end
          default: begin
            m_busy[i]--;
            if (m_busy[i] == 0) begin
              m_map[i]  = m_pmap[i];
              m_type[i] = m_ptype[i];
              m_wr[i]   = 1'b1;
              m_mode[i] = 1;
              if (i == 0) m_wcnt++;
            end
          end
        endcase
      end
    end
    if (rst) begin
      m_lfsr = SEED;
      m_vs   = 1'b0;
    end else begin
      m_lfsr = nxt;
      m_vs   = vsync;
    end
  end

  always @(negedge pclk) begin : scoreboard
    for (int i = 0; i < 3; i++) begin
      check($sformatf("ypos%0d", i), 32'(ypos_o[i]), 32'(m_ypos[i]));
      check($sformatf("map%0d", i), 32'(map_o[i]), 32'(m_map[i]));
      check($sformatf("type%0d", i), 32'(type_o[i]), 32'(m_type[i]));
      check($sformatf("wrapped%0d", i), 32'(wr_o[i]), 32'(m_wr[i]));
    end
    if (wr_o[0] === 1'b1) d_wcnt++;
  end

  task automatic vpulse(input int hi, input int lo);
    vsync = 1'b1;
    repeat (hi) @(negedge pclk);
    vsync = 1'b0;
    repeat (lo) @(negedge pclk);
  endtask

  initial begin : stim
    int w1, w2, w2_at;
    rst = 1'b1; vsync = 1'b0; en = 1'b0;
    foreach (spd[i]) spd[i] = 3'd3;
    repeat (3) @(negedge pclk);
    rst = 1'b0;
    check("rst_ypos", 32'(ypos_o[0]), 32'd0);
    check("rst_map", 32'(map_o[0]), 32'h7F);
    check("rst_type", 32'(type_o[0]), 32'd0);
    check("rst_wr", 32'(wr_o[0]), 32'd0);
    check("rst_ypos_720", 32'(ypos_o[1]), 32'd720);

    repeat (3) vpulse(4, 6);
    check("idle_hold", 32'(ypos_o[0]), 32'd0);

    en = 1'b1;
    spd[0] = 3'd3; spd[1] = 3'd7; spd[2] = 3'd7;
    repeat (2) @(negedge pclk);
    for (int p = 1; p <= 4; p++) begin
      vsync = 1'b1;
      @(negedge pclk);
      check($sformatf("step%0d", p), 32'(ypos_o[0]), 32'(3 * p));
      if (p == 1) begin
        check("wrap_ypos1", 32'(ypos_o[1]), 32'd2);
        check("wrap_ypos2", 32'(ypos_o[2]), 32'd2);
      end
      w1 = 0; w2 = 0; w2_at = -1;
      for (int j = 0; j < 20; j++) begin
        if (wr_o[1] === 1'b1) w1++;
        if (wr_o[2] === 1'b1) begin w2++; w2_at = j; end
        if (j == 11) vsync = 1'b0;
        @(negedge pclk);
      end
      check($sformatf("held_high%0d", p), 32'(ypos_o[0]), 32'(3 * p));
      if (p == 1) begin
        check("wr_pulses1", 32'(w1), 32'd1);
        check("wr_pulses2", 32'(w2), 32'd1);
        check("fallback_delay", 32'(w2_at), 32'd8);
        check("fallback_map", 32'(map_o[2]), 32'b0011100);
        check("fallback_type", 32'(type_o[2]), 32'd0);
        check("popcount_ok", 32'($countones(map_o[1]) >= 2), 32'd1);
      end
    end

    vsync = 1'b1; en = 1'b0;
    @(negedge pclk);
    check("drop_tick", 32'(ypos_o[0]), 32'd12);
    repeat (3) @(negedge pclk);
    vsync = 1'b0;
    repeat (4) @(negedge pclk);
    repeat (3) vpulse(3, 6);
    check("disabled_ticks", 32'(ypos_o[0]), 32'd12);
    en = 1'b1;
    foreach (spd[i]) spd[i] = 3'd0;
    repeat (3) @(negedge pclk);
    repeat (3) vpulse(3, 6);
    check("speed_zero", 32'(ypos_o[0]), 32'd12);

    rst = 1'b1;
    repeat (2) @(negedge pclk);
    rst = 1'b0; en = 1'b1;
    spd[0] = 3'd3; spd[1] = 3'd7; spd[2] = 3'd7;
    repeat (3) @(negedge pclk);
    vsync = 1'b1;
    @(negedge pclk);
    @(negedge pclk);
    rst = 1'b1; vsync = 1'b0;
    @(negedge pclk);
    rst = 1'b0;
    check("midregen_ypos", 32'(ypos_o[2]), 32'd720);
    check("midregen_map", 32'(map_o[2]), 32'h7F);
    check("midregen_wr", 32'(wr_o[2]), 32'd0);
    w2 = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge pclk);
      if (wr_o[2] === 1'b1) w2++;
    end
    check("midregen_nopulse", 32'(w2), 32'd0);

    for (int f = 0; f < 500; f++) begin
      en = ($urandom_range(0, 9) != 0);
      foreach (spd[i]) spd[i] = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        @(negedge pclk);
        rst = 1'b0;
      end
      vpulse($urandom_range(1, 10), $urandom_range(6, 14));
    end
    repeat (12) @(negedge pclk);
    check("wrap_count", 32'(d_wcnt), 32'(m_wcnt));
    check("wrap_count_min10", 32'(d_wcnt >= 10), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
